// File: rtl/usrt_pkg.sv
// Shared constants for the USRT APB front-end: register offsets, bit positions, data width.
package usrt_pkg;

  localparam int DATA_W = 8;

  // Register byte offsets
  localparam logic [7:0] ADDR_DATA   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_CTRL   = 8'h08;

  // STATUS bit positions
  localparam int ST_RX_NOT_EMPTY = 0;
  localparam int ST_TX_FULL      = 1;
  localparam int ST_RX_OVERRUN   = 2;
  localparam int ST_RX_ERR       = 3;

  // CTRL bit positions
  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_SOFT_RST = 1;

  // Decoded register selection
  typedef enum logic [1:0] {
    REG_DATA,
    REG_STATUS,
    REG_CTRL,
    REG_NONE
  } reg_sel_e;

endpackage

// File: rtl/usrt_rx_fifo.sv
// Small synchronous receive FIFO with flush; head byte is visible combinationally.
module usrt_rx_fifo
  import usrt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              push_ok, pop_ok;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_q];

  // A push into a full FIFO is only legal when the head leaves the same cycle
  assign push_ok = push_i & (~full_o | pop_i) & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;

  // Storage array; no reset needed since occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + PTR_W'(1);
      if (pop_ok)  rd_q <= rd_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/apb_usrt_slave.sv
// APB slave for the USRT: register decode, TX holding byte, RX FIFO, control/soft reset.
module apb_usrt_slave
  import usrt_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int RX_DEPTH = 4,
  parameter int WAIT_MAX = 255
) (
  input  logic              pClk,
  input  logic              pReset,
  input  logic              pSelect,
  input  logic              pEnable,
  input  logic              pWrite,
  input  logic [ADDR_W-1:0] pAddress,
  input  logic [DATA_W-1:0] pWData,
  output logic [DATA_W-1:0] pRData,
  output logic              pReady,
  output logic              pSlvErr,
  output logic [DATA_W-1:0] txData,
  output logic              txValid,
  input  logic              txReady,
  input  logic [DATA_W-1:0] rxData,
  input  logic              rxValid,
  input  logic              rxErr,
  output logic              clkEn,
  output logic              uRst
);

  localparam int WAIT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  reg_sel_e          reg_sel;
  logic              access, done;
  logic              tx_blocked, wait_expired;
  logic              tx_push, fifo_pop, fifo_push, soft_rst, ctrl_wr, st_w1c;
  logic              ovr_set, err_set;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head, status;

  logic [DATA_W-1:0] txdata_q, txdata_d;
  logic              txvalid_q, txvalid_d;
  logic              enable_q, enable_d;
  logic              urst_q, urst_d;
  logic              ovr_q, ovr_d;
  logic              rxerr_q, rxerr_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  assign access       = pSelect & pEnable;
  assign tx_blocked   = txvalid_q & ~txReady;
  assign wait_expired = (wait_q == WAIT_W'(WAIT_MAX));

  // Address decode over the full decoded slice; anything unmapped is an error
  always_comb begin
    reg_sel = REG_NONE;
    if (pAddress == ADDR_W'(ADDR_DATA))        reg_sel = REG_DATA;
    else if (pAddress == ADDR_W'(ADDR_STATUS)) reg_sel = REG_STATUS;
    else if (pAddress == ADDR_W'(ADDR_CTRL))   reg_sel = REG_CTRL;
  end

  // STATUS read image
  always_comb begin
    status                  = '0;
    status[ST_RX_NOT_EMPTY] = ~fifo_empty;
    status[ST_TX_FULL]      = txvalid_q;
    status[ST_RX_OVERRUN]   = ovr_q;
    status[ST_RX_ERR]       = rxerr_q;
  end

  // Combinational APB response during the access phase
  always_comb begin
    pReady  = 1'b0;
    pSlvErr = 1'b0;
    pRData  = '0;
    if (access) begin
      case (reg_sel)
        REG_DATA: begin
          if (pWrite) begin
            if (!tx_blocked) begin
              pReady = 1'b1;
            end else if (wait_expired) begin
              pReady  = 1'b1;
              pSlvErr = 1'b1;
            end
          end else if (fifo_empty) begin
            pReady  = 1'b1;
            pSlvErr = 1'b1;
          end else begin
            pReady = 1'b1;
            pRData = fifo_head;
          end
        end
        REG_STATUS: begin
          pReady = 1'b1;
          if (!pWrite) pRData = status;
        end
        REG_CTRL: begin
          pReady = 1'b1;
          if (!pWrite) pRData = {{(DATA_W-1){1'b0}}, enable_q};
        end
        default: begin
          pReady  = 1'b1;
          pSlvErr = 1'b1;
        end
      endcase
    end
  end

  // Side-effect strobes, all qualified by a completing transfer
  assign done      = access & pReady;
  assign tx_push   = done & pWrite & (reg_sel == REG_DATA) & ~pSlvErr;
  assign fifo_pop  = done & ~pWrite & (reg_sel == REG_DATA) & ~fifo_empty;
  assign ctrl_wr   = done & pWrite & (reg_sel == REG_CTRL);
  assign soft_rst  = ctrl_wr & pWData[CTRL_SOFT_RST];
  assign st_w1c    = done & pWrite & (reg_sel == REG_STATUS);
  // Deserializer pulses are ignored while the serdes is being reset
  assign fifo_push = rxValid & ~urst_q & (~fifo_full | fifo_pop);
  assign ovr_set   = rxValid & ~urst_q & fifo_full & ~fifo_pop;
  assign err_set   = rxErr & ~urst_q;

  // Next-state for holding byte, control, sticky flags and wait counter
  always_comb begin
    txdata_d  = txdata_q;
    txvalid_d = txvalid_q;
    enable_d  = enable_q;
    urst_d    = soft_rst;
    ovr_d     = ovr_q;
    rxerr_d   = rxerr_q;
    wait_d    = wait_q;

    if (soft_rst) begin
      txvalid_d = 1'b0;
    end else if (tx_push) begin
      txdata_d  = pWData;
      txvalid_d = 1'b1;
    end else if (txvalid_q && txReady) begin
      txvalid_d = 1'b0;
    end

    if (ctrl_wr) enable_d = pWData[CTRL_ENABLE];

    // Sticky set wins over a same-cycle W1C; soft reset clears both
    if (soft_rst) begin
      ovr_d   = 1'b0;
      rxerr_d = 1'b0;
    end else begin
      if (st_w1c && pWData[ST_RX_OVERRUN]) ovr_d = 1'b0;
      if (st_w1c && pWData[ST_RX_ERR])     rxerr_d = 1'b0;
      if (ovr_set) ovr_d = 1'b1;
      if (err_set) rxerr_d = 1'b1;
    end

    if (!pSelect || done) begin
      wait_d = '0;
    end else if (access && pWrite && (reg_sel == REG_DATA) && tx_blocked) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      txdata_q  <= '0;
      txvalid_q <= 1'b0;
      enable_q  <= 1'b0;
      urst_q    <= 1'b0;
      ovr_q     <= 1'b0;
      rxerr_q   <= 1'b0;
      wait_q    <= '0;
    end else begin
      txdata_q  <= txdata_d;
      txvalid_q <= txvalid_d;
      enable_q  <= enable_d;
      urst_q    <= urst_d;
      ovr_q     <= ovr_d;
      rxerr_q   <= rxerr_d;
      wait_q    <= wait_d;
    end
  end

  usrt_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (pClk),
    .rst_n   (pReset),
    .flush_i (soft_rst),
    .push_i  (fifo_push),
    .data_i  (rxData),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign txData  = txdata_q;
  assign txValid = txvalid_q;
  assign clkEn   = enable_q;
  assign uRst    = urst_q;

endmodule
